// File: rtl/hdmi_frame_scheduler_pkg.sv
// Shared types for the HDMI frame scheduler: FSM state encoding and CRC width.
`timescale 1ns/1ps
package hdmi_sched_pkg;

   localparam int CRC_W = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_CHECK = 3'd4,
      S_STOP  = 3'd5
   } sched_state_e;

endpackage

// File: rtl/hdmi_frame_scheduler_if.sv
// Core-side handshake: start pulse out, busy/end-of-frame/CRC back from the core and HDMI sink.
`timescale 1ns/1ps
interface hdmi_frame_scheduler_if;
   import hdmi_sched_pkg::*;

   logic             start_frame;
   logic             core_busy;
   logic             frame_done;
   logic [CRC_W-1:0] frame_crc;

   modport master (output start_frame, input core_busy, frame_done, frame_crc);
   modport slave  (input start_frame, output core_busy, frame_done, frame_crc);

endinterface

// File: rtl/hdmi_frame_scheduler_sat_counter.sv
// Saturating up-counter; clear dominates increment.
`timescale 1ns/1ps
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {WIDTH{1'b1}})) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/hdmi_frame_scheduler.sv
// Issues frame starts at a programmed cadence, waits for the sink's end of frame,
// checks the captured CRC against a golden value and keeps run statistics.
`timescale 1ns/1ps
module hdmi_frame_scheduler
   import hdmi_sched_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1048576,
   parameter int CNT_W       = 16,
   parameter int IVL_W       = 24
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_enable,
   input  logic [CNT_W-1:0]       cfg_num_frames,
   input  logic [IVL_W-1:0]       cfg_interval,
   input  logic [CRC_W-1:0]       cfg_golden_crc,
   input  logic                   cfg_golden_en,
   input  logic                   clear,
   hdmi_frame_scheduler_if.master core,
   output logic [CNT_W-1:0]       frames_started,
   output logic [CNT_W-1:0]       frames_done,
   output logic [CNT_W-1:0]       crc_mismatch_cnt,
   output logic [CRC_W-1:0]       last_crc,
   output logic                   sticky_mismatch,
   output logic                   sticky_timeout,
   output logic                   sticky_spurious,
   output logic                   run_complete_irq,
   output logic [2:0]             state
);

   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   sched_state_e     r_state;
   logic             r_start;
   logic             r_irq;
   logic [IVL_W-1:0] r_ivl;
   logic [TO_W-1:0]  r_to;
   logic [CRC_W-1:0] r_last_crc;
   logic             r_sticky_mm;
   logic             r_sticky_to;
   logic             r_sticky_sp;

   logic w_accept;
   logic w_timeout;
   logic w_mismatch;
   logic w_run_done;

   assign w_accept   = (r_state == S_WAIT) && core.frame_done;
   assign w_timeout  = (r_state == S_WAIT) && !core.frame_done && (r_to == TO_LAST);
   assign w_mismatch = (r_state == S_CHECK) && cfg_golden_en && (r_last_crc != cfg_golden_crc);
   assign w_run_done = (cfg_num_frames != '0) && (frames_done == cfg_num_frames);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_start <= 1'b0;
         r_irq   <= 1'b0;
         r_ivl   <= '0;
         r_to    <= '0;
      end else begin
         r_start <= 1'b0;
         r_irq   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cfg_enable) begin
                  r_state <= S_ARM;
                  r_ivl   <= '0;
               end
            end
            S_ARM: begin
               if (!cfg_enable) begin
                  r_state <= S_IDLE;
               end else if (r_ivl != '0) begin
                  r_ivl <= r_ivl - IVL_W'(1);
               end else if (!core.core_busy) begin
                  r_state <= S_START;
                  r_start <= 1'b1;
               end
            end
            S_START: begin
               r_state <= S_WAIT;
               r_to    <= '0;
            end
            // frame_done beats a same-cycle timeout; enable drops are ignored so the frame drains
            S_WAIT: begin
               if (core.frame_done) begin
                  r_state <= S_CHECK;
               end else if (r_to == TO_LAST) begin
                  r_state <= S_STOP;
                  r_irq   <= 1'b1;
               end else begin
                  r_to <= r_to + TO_W'(1);
               end
            end
            S_CHECK: begin
               if (w_run_done) begin
                  r_state <= S_STOP;
                  r_irq   <= 1'b1;
               end else if (!cfg_enable) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state <= S_ARM;
                  r_ivl   <= cfg_interval;
               end
            end
            S_STOP: begin
               if (!cfg_enable) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_last_crc  <= '0;
         r_sticky_mm <= 1'b0;
         r_sticky_to <= 1'b0;
         r_sticky_sp <= 1'b0;
      end else begin
         if (w_accept)   r_last_crc  <= core.frame_crc;
         if (w_mismatch) r_sticky_mm <= 1'b1;
         if (w_timeout)  r_sticky_to <= 1'b1;
         if (core.frame_done && (r_state != S_WAIT)) r_sticky_sp <= 1'b1;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_cnt_started (
      .clk(clk), .rst(rst), .i_inc(r_state == S_START), .i_clr(clear), .o_cnt(frames_started)
   );

   sat_counter #(.WIDTH(CNT_W)) u_cnt_done (
      .clk(clk), .rst(rst), .i_inc(w_accept), .i_clr(clear), .o_cnt(frames_done)
   );

   sat_counter #(.WIDTH(CNT_W)) u_cnt_mismatch (
      .clk(clk), .rst(rst), .i_inc(w_mismatch), .i_clr(clear), .o_cnt(crc_mismatch_cnt)
   );

   assign core.start_frame = r_start;
   assign last_crc         = r_last_crc;
   assign sticky_mismatch  = r_sticky_mm;
   assign sticky_timeout   = r_sticky_to;
   assign sticky_spurious  = r_sticky_sp;
   assign run_complete_irq = r_irq;
   assign state            = r_state;

endmodule

// File: doc/hdmi_frame_scheduler.md
# hdmi_frame_scheduler

Sequences frame rendering for the voxel display pipeline. It issues `start_frame` pulses to the voxel core at a programmed cadence and waits for the HDMI sink's end-of-frame indication. It then captures the sink CRC, compares it against a golden value, and keeps frame, mismatch and error statistics. It sits between the AXI-Lite control registers (configuration and status) and the core's start/HDMI-monitor signals, replacing software-timed start writes.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1048576: cycles allowed in WAIT_DONE before a timeout is declared; minimum 1.
- `CNT_W`, default 16: width of the frame and mismatch counters.
- `IVL_W`, default 24: width of the inter-frame interval.

Ports:
- `clk`  in  1: sole clock.
- `rst`  in  1: synchronous, active-high reset.
- `cfg_enable`  in  1: run enable (level).
- `cfg_num_frames`  in  CNT_W: frames to run; 0 means unbounded.
- `cfg_interval`  in  IVL_W: idle cycles between a frame's check and the next start.
- `cfg_golden_crc`  in  32: expected per-frame CRC.
- `cfg_golden_en`  in  1: enable CRC comparison.
- `clear`  in  1: pulse; zeroes counters and sticky flags.
- `core_busy`  in  1: the core is still rendering; a start must not be issued while it is high.
- `start_frame`  out  1: one-cycle start pulse to the core.
- `frame_done`  in  1: one-cycle end-of-frame pulse from the HDMI sink.
- `frame_crc`  in  32: sink CRC, valid only with `frame_done`.
- `frames_started`  out  CNT_W: saturating count of starts issued.
- `frames_done`  out  CNT_W: saturating count of frames completed.
- `crc_mismatch_cnt`  out  CNT_W: saturating count of CRC mismatches.
- `last_crc`  out  32: CRC captured at the most recent accepted `frame_done`.
- `sticky_mismatch`  out  1: a CRC mismatch has occurred since the last clear.
- `sticky_timeout`  out  1: a WAIT_DONE timeout has occurred since the last clear.
- `sticky_spurious`  out  1: a `frame_done` arrived outside WAIT_DONE.
- `run_complete_irq`  out  1: one-cycle pulse at run end.
- `state`  out  3: current FSM state.

## Operation
- States: IDLE=0, ARM=1, START=2, WAIT_DONE=3, CHECK=4, STOP=5.
- IDLE: when `cfg_enable` is high, go to ARM; the interval counter loads 0, so the first start is not delayed.
- ARM:
  - Interval counter decrements to 0.
  - At 0 with `core_busy` low, go to START.
  - If `cfg_enable` drops, return to IDLE immediately.
- START:
  - `start_frame` is high for exactly this cycle; `frames_started` increments.
  - Next state is WAIT_DONE; the timeout counter clears.
- WAIT_DONE:
  - On `frame_done`: capture `frame_crc` into `last_crc`, increment `frames_done`, go to CHECK.
  - If the timeout counter reaches TIMEOUT_CYC-1 without `frame_done`: set `sticky_timeout`, go to STOP.
  - If `frame_done` and timeout expiry occur in the same cycle, `frame_done` wins.
  - A drop of `cfg_enable` is ignored here; the current frame drains.
- CHECK (single cycle):
  - If `cfg_golden_en` is high and `last_crc != cfg_golden_crc`: increment `crc_mismatch_cnt`, set `sticky_mismatch`.
  - If `cfg_num_frames != 0` and `frames_done == cfg_num_frames`: go to STOP.
  - Otherwise, if `cfg_enable` is low: go to IDLE.
  - Otherwise: go to ARM, loading `cfg_interval`.
- STOP:
  - `run_complete_irq` pulses on the entry cycle only.
  - Remain in STOP until `cfg_enable` is low, then go to IDLE.
- `frame_done` in any state other than WAIT_DONE sets `sticky_spurious`; the CRC is not captured and no counter changes.
- All counters saturate at 2^CNT_W−1 and never wrap.
- `clear`:
  - Zeroes all counters, sticky flags and `last_crc`; the FSM state is unaffected.
  - It takes priority over any increment or set in the same cycle.
  - Clearing mid-run makes the `frames_done == cfg_num_frames` test restart from zero.
- Configuration inputs are sampled live. Software changes `cfg_*` only in IDLE or STOP; behaviour otherwise is defined by the sampling rules above but is not required to be meaningful.

## Timing
- Reset: state IDLE; all outputs 0; `last_crc` 0.
- Start-to-start latency with `core_busy` low = frame time + 2 (START, CHECK) + `cfg_interval` + 1 ARM cycle.
- The first start is issued 2 cycles after `cfg_enable` rises in IDLE (IDLE→ARM→START).
- `start_frame` is registered, never combinational from inputs.
- Status outputs update in the cycle after the triggering event.
- The timeout counter is log2(TIMEOUT_CYC) bits and counts only in WAIT_DONE.
- Reset mid-frame: returns to IDLE next cycle; no `start_frame` and no irq are emitted.

## Structure
- Package `hdmi_sched_pkg`: state enum `sched_state_e` (3 bits, encodings above) and `CRC_W = 32`.
- Sub-module `sat_counter` (param WIDTH; inc, clr; clr dominant), instantiated three times.
- FSM and compare logic live in the top level.

## Test plan
- Single frame: `cfg_num_frames`=1, golden disabled; `frame_done` 50 cycles after start with CRC 0xDEADBEEF → exactly one `start_frame`, `last_crc`=0xDEADBEEF, `frames_done`=1, irq one pulse, state STOP.
- Cadence: `cfg_num_frames`=3, `cfg_interval`=10, `frame_done` 20 cycles after each start → three starts, spacing 20+2+10+1 cycles, `frames_started`=3, `frames_done`=3.
- CRC check: golden 0x12345678 enabled; frames return 0x12345678, 0x0, 0x12345678 → `crc_mismatch_cnt`=1, `sticky_mismatch`=1.
- Timeout: TIMEOUT_CYC=64, no `frame_done` → `sticky_timeout` set on the 64th WAIT_DONE cycle, state STOP; `frame_done` coincident with the last cycle → CHECK, no timeout.
- Busy and spurious: `core_busy` high for 30 cycles in ARM → start delayed to the cycle after it falls; `frame_done` pulse in ARM → `sticky_spurious`=1, counters unchanged.
- Clear and reset: `clear` coincident with `frame_done` → counters 0 next cycle; `rst` asserted in WAIT_DONE → IDLE, all outputs 0, no irq.
